pixel_deserializer: RTL and testbench

- Serial-in, parallel-out receiver for the pixel bit stream produced by the parallel-load pixel shift register.
- Collects bits MSB-first into a WIDTH-bit row word and presents each completed word on a valid/ready output port.
- Double-buffered: the next row keeps shifting in while the previous word waits for the consumer, such as a row buffer or frame memory writer.

---
 rtl/pixel_deserializer.sv | 85 ++++++++
 tb/tb_pixel_deserializer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_deserializer.sv
// Serial-to-parallel pixel row receiver with a double-buffered valid/ready output.
// Define DESER_LSB_FIRST_EN for LSB-first reception (default is MSB-first).
module pixel_deserializer #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             clear_n,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CNT_W-1:0] bit_count,
  output logic             overflow
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic             complete;

`ifdef DESER_LSB_FIRST_EN
  assign shifted = {serial_in, shreg[WIDTH-1:1]};
`else
  assign shifted = {shreg[WIDTH-2:0], serial_in};
`endif

  assign complete   = bit_valid && (bit_count == LAST);
  assign word_valid = (state == FULL);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg     <= '0;
      bit_count <= '0;
      word_out  <= '0;
      state     <= EMPTY;
      overflow  <= 1'b0;
    end else if (!clear_n) begin
      shreg     <= '0;
      bit_count <= '0;
      state     <= EMPTY;
      overflow  <= 1'b0;
    end else begin
      if (complete) begin
        shreg     <= '0;
        bit_count <= '0;
      end else if (bit_valid) begin
        shreg     <= shifted;
        bit_count <= bit_count + 1'b1;
      end

      // A completed word lands unless the held word is neither taken nor free.
      unique case (state)
        EMPTY: begin
          if (complete) begin
            word_out <= shifted;
            state    <= FULL;
          end
        end
        FULL: begin
          if (word_ready) begin
            if (complete) begin
              word_out <= shifted;
            end else begin
              state <= EMPTY;
            end
          end else if (complete) begin
            overflow <= 1'b1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_deserializer.sv
// Scoreboard bench for pixel_deserializer: expected words queued at send time,
// compared at each valid/ready handshake.
module tb_pixel_deserializer;

  localparam int W = 128;
  localparam int CW = 7;

  logic          clock;
  logic          reset;
  logic          serial_in;
  logic          bit_valid;
  logic          clear_n;
  logic [W-1:0]  word_out;
  logic          word_valid;
  logic          word_ready;
  logic [CW-1:0] bit_count;
  logic          overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] sb_q[$];

  pixel_deserializer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .serial_in (serial_in),
    .bit_valid (bit_valid),
    .clear_n   (clear_n),
    .word_out  (word_out),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .bit_count (bit_count),
    .overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic bit_of(input logic [W-1:0] w, input int k);
`ifdef DESER_LSB_FIRST_EN
    return w[k];
`else
    return w[W-1-k];
`endif
  endfunction

  // Handshake monitor: a word is taken at the edge following this sample.
  always @(negedge clock) begin
    logic [W-1:0] exp_w;
    if (reset && clear_n && word_valid && word_ready) begin
      exp_w = (sb_q.size() != 0) ? sb_q.pop_front() : ~word_out;
      check("sb_word", word_out, exp_w);
    end
  end

  task automatic send_word(input logic [W-1:0] w,
                           input bit gaps,
                           input bit rdy_last);
    for (int k = 0; k < W; k++) begin
      serial_in = bit_of(w, k);
      bit_valid = 1'b1;
      if (rdy_last && k == W - 1) word_ready = 1'b1;
      step();
      if (gaps && (k == 0 || k == 63 || k == 126)) begin
        bit_valid = 1'b0;
        serial_in = ~serial_in;
        repeat (3) begin
          step();
          check("gap_cnt", W'(bit_count), W'(k + 1));
          check("gap_valid", W'(word_valid), '0);
        end
      end
    end
    bit_valid = 1'b0;
    if (rdy_last) word_ready = 1'b0;
  endtask

  task automatic accept_one();
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
  endtask

  localparam logic [W-1:0] W_BASIC = {1'b1, {(W-2){1'b0}}, 1'b1};
  localparam logic [W-1:0] W_AA    = {(W/8){8'hAA}};
  localparam logic [W-1:0] W_55    = {(W/8){8'h55}};
  localparam logic [W-1:0] W_0F    = {(W/8){8'h0F}};
  localparam logic [W-1:0] W_F0    = {(W/8){8'hF0}};
  localparam logic [W-1:0] W_FRESH = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [W-1:0] W_JUNK  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

  initial begin
    reset      = 1'b0;
    serial_in  = 1'b0;
    bit_valid  = 1'b0;
    clear_n    = 1'b1;
    word_ready = 1'b0;
    repeat (3) step();
    check("rst_out", word_out, '0);
    check("rst_valid", W'(word_valid), '0);
    check("rst_cnt", W'(bit_count), '0);
    check("rst_ovf", W'(overflow), '0);
    reset = 1'b1;
    step();

    // basic word, MSB first
    sb_q.push_back(W_BASIC);
    send_word(W_BASIC, 1'b0, 1'b0);
    check("basic_valid", W'(word_valid), W'(1));
    check("basic_out", word_out, W_BASIC);
    check("basic_cnt", W'(bit_count), '0);
    accept_one();
    check("basic_drain", W'(word_valid), '0);

    // gapped input
    sb_q.push_back(W_BASIC);
    send_word(W_BASIC, 1'b1, 1'b0);
    check("gap_out", word_out, W_BASIC);
    check("gap_v1", W'(word_valid), W'(1));
    accept_one();

    // back-to-back with ready held high
    word_ready = 1'b1;
    sb_q.push_back(W_AA);
    send_word(W_AA, 1'b0, 1'b0);
    check("b2b_aa", word_out, W_AA);
    sb_q.push_back(W_55);
    send_word(W_55, 1'b0, 1'b0);
    check("b2b_55", word_out, W_55);
    check("b2b_ovf", W'(overflow), '0);
    step();
    word_ready = 1'b0;
    check("b2b_drain", W'(word_valid), '0);

    // accept and complete on the same edge
    sb_q.push_back(W_AA);
    send_word(W_AA, 1'b0, 1'b0);
    sb_q.push_back(W_55);
    send_word(W_55, 1'b0, 1'b1);
    check("hand_valid", W'(word_valid), W'(1));
    check("hand_out", word_out, W_55);
    check("hand_ovf", W'(overflow), '0);
    accept_one();
    check("hand_drain", W'(word_valid), '0);

    // overflow
    sb_q.push_back(W_0F);
    send_word(W_0F, 1'b0, 1'b0);
    for (int k = 0; k < W - 1; k++) begin
      serial_in = bit_of(W_F0, k);
      bit_valid = 1'b1;
      step();
    end
    check("ovf_pre", W'(overflow), '0);
    serial_in = bit_of(W_F0, W - 1);
    step();
    bit_valid = 1'b0;
    check("ovf_set", W'(overflow), W'(1));
    check("ovf_out", word_out, W_0F);
    accept_one();
    check("ovf_drain", W'(word_valid), '0);
    check("ovf_sticky", W'(overflow), W'(1));

    // synchronous abort after 50 bits
    for (int k = 0; k < 50; k++) begin
      serial_in = bit_of(W_JUNK, k);
      bit_valid = 1'b1;
      step();
    end
    check("pre_clr_cnt", W'(bit_count), W'(50));
    clear_n = 1'b0;
    serial_in = 1'b1;
    step();
    clear_n = 1'b1;
    bit_valid = 1'b0;
    check("clr_cnt", W'(bit_count), '0);
    check("clr_valid", W'(word_valid), '0);
    check("clr_ovf", W'(overflow), '0);
    check("clr_out", word_out, W_0F);
    sb_q.push_back(W_FRESH);
    send_word(W_FRESH, 1'b0, 1'b0);
    check("fresh_out", word_out, W_FRESH);
    accept_one();

    // asynchronous reset mid-word with a word held
    send_word(W_AA, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      serial_in = 1'b1;
      bit_valid = 1'b1;
      step();
    end
    bit_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("arst_out", word_out, '0);
    check("arst_valid", W'(word_valid), '0);
    check("arst_cnt", W'(bit_count), '0);
    check("arst_ovf", W'(overflow), '0);
    step();
    reset = 1'b1;
    step();

`ifdef DESER_LSB_FIRST_EN
    sb_q.push_back({{(W-1){1'b0}}, 1'b1});
    send_word({{(W-1){1'b0}}, 1'b1}, 1'b0, 1'b0);
    check("lsb_out", word_out, {{(W-1){1'b0}}, 1'b1});
    accept_one();
`endif

    step();
    check("sb_left", W'(sb_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
